tri_stim_gen: RTL and testbench
===============================

Name: tri_stim_gen

Overview:
- Synthesizable triangle stimulus source. It is the transmit end of the triangle/sample stream that the rasterizer consumes and the performance monitor observes.
- Generates a programmed number of pseudo-random triangles with colors from an LFSR.
- Presents each triangle on a valid/halt handshake into the rasterizer front end and counts accepted triangles for perf cross-checking.

Parameters:
- SIGFIG, 24, bits in color and position words.
- RADIX, 10, fraction bits in position; informational only, no arithmetic depends on it.
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x,y,z).
- COLORS, 3, color channels.
- SEED, 32'h0000_0001, LFSR reset value; must be nonzero.
- COORD_MASK, 24'h003FFF, AND-mask applied to x/y words.
- COLOR_MASK, 24'h000FFF, AND-mask applied to color words.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-low reset, sampled on posedge clk.
- start, input, 1, single-cycle request to begin a batch; honoured only in IDLE or DONE.
- num_tri, input, 16, triangles in the batch; sampled when start is honoured.
- halt_RnnnnL, input, 1, downstream ready; 1 = accept, 0 = stall.
- tri_R10S, output, SIGFIG x [VERTS][AXIS], signed vertex positions.
- color_R10U, output, SIGFIG x [COLORS], unsigned colors.
- validTri_R10H, output, 1, triangle valid.
- tri_count, output, 16, triangles accepted in the current batch.
- busy, output, 1, high in GEN or HOLD.
- done, output, 1, high in DONE.

Behaviour:
- Reset (rst==0 at posedge) forces:
  - state=IDLE, lfsr=SEED.
  - All tri_R10S and color_R10U words = 0.
  - validTri_R10H=0, tri_count=0, busy=0, done=0.
  - Reset asserted mid-batch abandons the batch with no acceptance.
- LFSR: 32-bit Galois, right shift. next = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0). It steps exactly once per GEN cycle and holds in all other states.
- Word capture: each GEN cycle writes one output word from the stepped value ("next"), in this order:
  - v0.x, v0.y, v1.x, v1.y, ..., v(VERTS-1).y, then color0..color(COLORS-1).
  - Position word = next[SIGFIG-1:0] & COORD_MASK.
  - Color word = next[SIGFIG-1:0] & COLOR_MASK.
  - All z words are written 0.
  - GEN therefore lasts 2*VERTS+COLORS cycles (9 by default), tracked by a word index counter.
- States:
  - IDLE: wait for start. On start, latch num_tri, clear tri_count, and go to GEN. If num_tri==0, go directly to DONE instead.
  - GEN: fill words; validTri_R10H=0. After the last word, go to HOLD.
  - HOLD: validTri_R10H=1.
    - Transfer occurs on any posedge with validTri_R10H & halt_RnnnnL.
    - On transfer, tri_count increments. If the new count equals num_tri, go to DONE; otherwise go to GEN and clear the word index.
    - Under stall (halt_RnnnnL==0), all tri/color outputs and valid hold stable for any number of cycles.
  - DONE: done=1 and outputs hold their last values, with valid=0.
    - On start, return to GEN (or stay in DONE if num_tri==0) with tri_count cleared.
    - The LFSR is not reseeded, so the sequence continues.
- Valid is never asserted in GEN, so there are no back-to-back transfers. Minimum spacing between transfers is 2*VERTS+COLORS+1 cycles.
- start in GEN or HOLD is ignored; num_tri is not re-sampled.
- Reset has priority over start in the same cycle.
- tri_count is 16 bits and cannot overflow, because it stops at num_tri (max 65535).
- Output words are registered with no combinational path from inputs. halt_RnnnnL affects only next-state.

Test Plan:
- Reset then start, num_tri=1, halt_RnnnnL=1, defaults → after 9 GEN cycles valid rises. Required values: tri_R10S[0][0]=24'h000003 (first step from SEED 1 gives 0x80200003), all z=0. Transfer occurs the same cycle, tri_count=1, done=1 the next cycle.
- num_tri=4, halt_RnnnnL=1 throughout → exactly 4 valid pulses spaced 10 cycles apart; tri_count 1..4; done after the 4th transfer.
- num_tri=2, halt_RnnnnL=0 for 20 cycles during the first HOLD → outputs and valid bit-identical across all stall cycles; one transfer when halt_RnnnnL rises; tri_count=1.
- Reset in the 5th GEN cycle, then start num_tri=1 → output words identical to scenario 1 (LFSR reseeded); no transfer before reset.
- num_tri=0 start → DONE the next cycle, valid never asserted, tri_count=0. A second start with num_tri=1 yields one transfer. A start pulse during GEN is ignored.
- Back-to-back batches: num_tri=1 twice, no reset → the second batch's v0.x equals the 10th LFSR step masked, not 24'h000003.

Source files
------------

// File: rtl/tri_stim_gen.sv
// Triangle stimulus source: LFSR-filled vertex/color words presented on a
// valid/halt handshake, with a count of accepted triangles per batch.
module tri_stim_gen #(
    parameter int                SIGFIG     = 24,
    parameter int                RADIX      = 10,
    parameter int                VERTS      = 3,
    parameter int                AXIS       = 3,
    parameter int                COLORS     = 3,
    parameter logic [31:0]       SEED       = 32'h0000_0001,
    parameter logic [SIGFIG-1:0] COORD_MASK = 24'h003FFF,
    parameter logic [SIGFIG-1:0] COLOR_MASK = 24'h000FFF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [15:0]                                num_tri,
    input  logic                                       halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic [COLORS-1:0][SIGFIG-1:0]              color_R10U,
    output logic                                       validTri_R10H,
    output logic [15:0]                                tri_count,
    output logic                                       busy,
    output logic                                       done
);

    localparam int NWORDS = 2 * VERTS + COLORS;
    localparam int WIDX_W = $clog2(NWORDS + 1);

    // RADIX is carried for downstream documentation only; reject bad setups.
    if (RADIX >= SIGFIG || SEED == 32'h0) begin : g_param_err
        $error("tri_stim_gen: bad RADIX or zero SEED");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_HOLD,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [15:0] num_q, num_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0] col_q, col_d;
    logic [SIGFIG-1:0] pos_w, col_w;

    assign lfsr_nxt = {1'b0, lfsr_q[31:1]}
                    ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    assign pos_w    = lfsr_nxt[SIGFIG-1:0] & COORD_MASK;
    assign col_w    = lfsr_nxt[SIGFIG-1:0] & COLOR_MASK;
    assign cnt_inc  = cnt_q + 16'd1;

    // Next-state, LFSR stepping, word index and batch counters.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        widx_d  = widx_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d   = num_tri;
                    cnt_d   = '0;
                    widx_d  = '0;
                    state_d = (num_tri == 16'd0) ? S_DONE : S_GEN;
                end
            end
            S_GEN: begin
                lfsr_d = lfsr_nxt;
                if (widx_q == WIDX_W'(NWORDS - 1)) begin
                    widx_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    widx_d = widx_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (halt_RnnnnL) begin
                    cnt_d   = cnt_inc;
                    widx_d  = '0;
                    state_d = (cnt_inc == num_q) ? S_DONE : S_GEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One output word captured per GEN cycle; z words are never written.
    always_comb begin
        tri_d = tri_q;
        col_d = col_q;
        if (state_q == S_GEN) begin
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < 2; a++) begin
                    if (widx_q == WIDX_W'(2 * v + a)) tri_d[v][a] = pos_w;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                if (widx_q == WIDX_W'(2 * VERTS + c)) col_d[c] = col_w;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            widx_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            tri_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            widx_q  <= widx_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            tri_q   <= tri_d;
            col_q   <= col_d;
        end
    end

    assign tri_R10S      = tri_q;
    assign color_R10U    = col_q;
    assign validTri_R10H = (state_q == S_HOLD);
    assign busy          = (state_q == S_GEN) || (state_q == S_HOLD);
    assign done          = (state_q == S_DONE);
    assign tri_count     = cnt_q;

endmodule

// File: tb/tb_tri_stim_gen.sv
// Bench for tri_stim_gen: transaction-level reference model plus
// directed scenarios and a randomized handshake phase.
module tb_tri_stim_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [15:0] num_tri = 16'd0;
    logic halt_RnnnnL = 1'b1;
    logic [2:0][2:0][23:0] tri_o;
    logic [2:0][23:0] col_o;
    logic valid_o, busy_o, done_o;
    logic [15:0] cnt_o;

    int checks = 0;
    int errors = 0;

    tri_stim_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_tri      (num_tri),
        .halt_RnnnnL  (halt_RnnnnL),
        .tri_R10S     (tri_o),
        .color_R10U   (col_o),
        .validTri_R10H(valid_o),
        .tri_count    (cnt_o),
        .busy         (busy_o),
        .done         (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_lfsr = 32'h1;
    logic [23:0] m_tri[3][3];
    logic [23:0] m_col[3];
    logic [23:0] p_tri[3][3];
    logic [23:0] p_col[3];
    int  m_gen_left = 0;
    bit  m_valid = 0, m_busy = 0, m_done = 0;
    int  m_cnt = 0, m_num = 0;
    int  m_xfers = 0, m_gap = 0, m_last = -1, cyc = 0;
    bit  chk_en = 0;

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Precompute a whole triangle: nine successive LFSR values.
    task automatic begin_tri();
        logic [23:0] w;
        for (int v = 0; v < 3; v++) p_tri[v][2] = '0;
        for (int i = 0; i < 9; i++) begin
            m_lfsr = step(m_lfsr);
            w = m_lfsr[23:0];
            if (i < 6) p_tri[i / 2][i % 2] = w & 24'h003FFF;
            else p_col[i - 6] = w & 24'h000FFF;
        end
        m_gen_left = 9;
        m_valid = 0;
        m_busy = 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_lfsr = 32'h1;
            for (int v = 0; v < 3; v++) begin
                m_col[v] = '0;
                for (int a = 0; a < 3; a++) m_tri[v][a] = '0;
            end
            m_gen_left = 0;
            m_valid = 0;
            m_busy = 0;
            m_done = 0;
            m_cnt = 0;
            m_num = 0;
        end else if (m_valid) begin
            if (halt_RnnnnL) begin
                m_cnt++;
                m_xfers++;
                if (m_last >= 0) m_gap = cyc - m_last;
                m_last = cyc;
                if (m_cnt == m_num) begin
                    m_valid = 0;
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    begin_tri();
                end
            end
        end else if (m_gen_left > 0) begin
            m_gen_left--;
            if (m_gen_left == 0) begin
                m_valid = 1;
                m_tri = p_tri;
                m_col = p_col;
            end
        end else if (start) begin
            m_num = int'(num_tri);
            m_cnt = 0;
            m_xfers = 0;
            m_last = -1;
            if (num_tri == 16'd0) m_done = 1;
            else begin
                m_done = 0;
                begin_tri();
            end
        end
    end

    // Per-cycle comparison; words are meaningful when presented or at rest.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(valid_o), 64'(m_valid));
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("done", 64'(done_o), 64'(m_done));
            chk("tri_count", 64'(cnt_o), 64'(m_cnt));
            if (m_valid || !m_busy) begin
                for (int v = 0; v < 3; v++) begin
                    chk($sformatf("color%0d", v), 64'(col_o[v]), 64'(m_col[v]));
                    for (int a = 0; a < 3; a++)
                        chk($sformatf("tri_v%0d_a%0d", v, a),
                            64'(tri_o[v][a]), 64'(m_tri[v][a]));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num_tri = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int k = 0;
        while (!valid_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for valid", nm);
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while (!done_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done", nm);
        end
    endtask

    logic [2:0][2:0][23:0] snap_tri;
    logic [2:0][23:0] snap_col;

    initial begin
        halt_RnnnnL = 1'b1;
        do_reset(2);
        chk_en = 1;
        @(negedge clk);
        chk("rst_count", 64'(cnt_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_v0x", 64'(tri_o[0][0]), 64'd0);

        // Single triangle from the seed.
        pulse_start(16'd1);
        wait_valid("s1", 40);
        chk("s1_v0x", 64'(tri_o[0][0]), 64'h000003);
        chk("s1_v0y", 64'(tri_o[0][1]), 64'h000002);
        chk("s1_v2z", 64'(tri_o[2][2]), 64'h0);
        chk("s1_col0", 64'(col_o[0]), 64'h003);
        chk("s1_col2", 64'(col_o[2]), 64'h001);
        @(negedge clk);
        chk("s1_done", 64'(done_o), 64'd1);
        chk("s1_count", 64'(cnt_o), 64'd1);

        // Four triangles with no stalls: ten-cycle spacing.
        pulse_start(16'd4);
        wait_done("s2", 200);
        chk("s2_xfers", 64'(m_xfers), 64'd4);
        chk("s2_gap", 64'(m_gap), 64'd10);
        chk("s2_count", 64'(cnt_o), 64'd4);

        // Stall for 20 cycles during the first HOLD.
        pulse_start(16'd2);
        wait_valid("s3", 40);
        halt_RnnnnL = 1'b0;
        snap_tri = tri_o;
        snap_col = col_o;
        repeat (20) begin
            @(negedge clk);
            chk("s3_stall_tri", 64'(tri_o == snap_tri), 64'd1);
            chk("s3_stall_col", 64'(col_o == snap_col), 64'd1);
            chk("s3_stall_valid", 64'(valid_o), 64'd1);
        end
        halt_RnnnnL = 1'b1;
        @(negedge clk);
        chk("s3_count1", 64'(cnt_o), 64'd1);
        chk("s3_valid_drop", 64'(valid_o), 64'd0);
        wait_done("s3", 100);

        // Reset in the 5th GEN cycle reseeds the LFSR.
        pulse_start(16'd1);
        repeat (4) @(negedge clk);
        do_reset(1);
        chk("s4_noxfer", 64'(m_xfers), 64'd0);
        chk("s4_count", 64'(cnt_o), 64'd0);
        pulse_start(16'd1);
        wait_valid("s4", 40);
        chk("s4_v0x", 64'(tri_o[0][0]), 64'h000003);
        chk("s4_col0", 64'(col_o[0]), 64'h003);
        wait_done("s4", 20);

        // Zero-length batch, then a batch with a start during GEN.
        pulse_start(16'd0);
        chk("s5_done0", 64'(done_o), 64'd1);
        chk("s5_count0", 64'(cnt_o), 64'd0);
        chk("s5_valid0", 64'(valid_o), 64'd0);
        pulse_start(16'd1);
        repeat (2) @(negedge clk);
        pulse_start(16'd7);
        wait_done("s5", 100);
        chk("s5_xfers", 64'(m_xfers), 64'd1);
        chk("s5_count1", 64'(cnt_o), 64'd1);

        // Back-to-back batches without reset: sequence continues.
        do_reset(1);
        pulse_start(16'd1);
        wait_done("s6a", 40);
        pulse_start(16'd1);
        wait_valid("s6", 40);
        chk("s6_v0x", 64'(tri_o[0][0]), 64'h003003);
        wait_done("s6b", 20);

        // Randomized handshake, starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            halt_RnnnnL = ($urandom % 3) != 0;
            start = ($urandom % 10) == 0;
            num_tri = 16'($urandom_range(0, 5));
            rst = ($urandom % 400) != 0;
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        halt_RnnnnL = 1'b1;
        repeat (80) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
